cpri_rx_sched: RTL
==================

Name: cpri_rx_sched

Overview:
- Round-robin read scheduler for LANE_NUM CPRI receive lanes; each lane is one CPRI RX loop-buffer reader instance.
- Grants one lane at a time a full-chip read burst: one rready pulse train of CHIP_WORDS cycles, covering word addresses 7..90.
- Emits a latency-aligned lane select and framing so the downstream lane mux can pick the right 64-bit IQ stream.
- Sits between the per-lane RX readers and the PUSCH dimension-reduction input mux.

Parameters:
- LANE_NUM, 4, number of CPRI lanes arbitrated (2..8).
- CHIP_WORDS, 84, rready cycles per chip burst (address 7..90 inclusive).
- GAP_CYCLES, 2, idle cycles after each burst so the lane's buffer valid can update.
- SEL_LATENCY, 3, delay from rready to IQ data at the lane output.
- SEL_W, $clog2(LANE_NUM), select width.

Ports:
- rd_clk  in  1  scheduler clock; same domain as the lane read side.
- rd_rst  in  1  asynchronous, active-high reset.
- i_rx_enable  in  1  global scheduling enable.
- i_lane_en  in  LANE_NUM  per-lane static enable mask.
- i_lane_vld  in  LANE_NUM  lane buffer holds at least one complete chip.
- o_rready  out  LANE_NUM  one-hot read-ready to the lanes.
- o_sel  out  SEL_W  lane index aligned to the output data.
- o_sel_vld  out  1  o_sel/data valid.
- o_sof  out  1  first word of a chip at the output.
- o_eof  out  1  last word of a chip at the output.
- o_chip_done  out  1  one-cycle pulse at burst end, unaligned.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Clock and reset: single clock rd_clk; reset rd_rst is asynchronous and active-high. All flops reset via rd_rst.
- Reset values: all outputs 0; rr_ptr=0; word_cnt=0; FSM in IDLE; delay pipelines cleared.
- Request vector: req = i_lane_vld & i_lane_en.
- IDLE: go to ARB when i_rx_enable=1.
- ARB: if i_rx_enable=0, go to IDLE. Else if req!=0, pick the first set bit at or after rr_ptr (circular). Latch it as grant, set rr_ptr=grant+1 mod LANE_NUM, go to BURST. If req=0, stay in ARB.
- BURST: o_rready[grant]=1, all other bits 0.
  - word_cnt increments 0..CHIP_WORDS-1.
  - On word_cnt==CHIP_WORDS-1: pulse o_chip_done, clear word_cnt, go to GAP.
- GAP: hold for GAP_CYCLES cycles. Then go to ARB if i_rx_enable=1, else IDLE.
- Burst atomicity: a started burst is never truncated.
  - A drop of i_rx_enable, i_lane_en or i_lane_vld during BURST is ignored until the burst ends.
  - Truncation would desynchronise the lane read address from its chip boundary.
- Minimum period: ARB costs 1 cycle, so back-to-back chips take CHIP_WORDS+GAP_CYCLES+1 cycles. o_rready never has two bits set.
- Output alignment: a pipeline of depth SEL_LATENCY carries {burst_active, grant, word_cnt==0, word_cnt==CHIP_WORDS-1}.
  - o_sel_vld, o_sel, o_sof and o_eof are that pipeline's last stage.
  - o_sof/o_eof are asserted only with o_sel_vld.
- LANE_NUM=1: rr_ptr stays 0; scheduling degenerates to the same lane each round.
- Simultaneous requests: the one nearest rr_ptr wins. A lane asserting req in the same cycle as ARB is eligible.
- o_busy = (state!=IDLE).
- Reset mid-burst: everything clears immediately, o_rready=0. The lane restarts from address 7 on its own valid-deassert behaviour.

Optional Feature:
- Macro CPRI_RX_SCHED_STAT_EN.
- Defined: per-lane 16-bit wrapping chip counters, incremented at burst end of the granted lane, exposed on output o_chip_cnt (LANE_NUM x 16).
  - Also a 16-bit saturating o_stall_cnt, counting ARB cycles with i_rx_enable=1 and req=0.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Decomposition:
- Shared package cpri_rx_pkg: state enum sched_st_t {IDLE, ARB, BURST, GAP}, constant CPRI_CHIP_WORDS=84, constant CPRI_FIRST_ADDR=7, constant CPRI_LAST_ADDR=90.
- One natural sub-module: rr_arbiter, combinational. Inputs req and rr_ptr; outputs grant index and grant_vld.
- The FSM and the alignment pipeline stay in cpri_rx_sched.

Test Plan:
- Reset, single lane: LANE_NUM=4, i_lane_vld=4'b0100, enable=1.
  - o_rready=4'b0100 for exactly 84 cycles, starting 2 cycles after enable.
  - o_sof at the 3rd cycle after the first rready, o_eof 83 cycles later, o_sel=2.
- All lanes valid continuously: grants follow 0,1,2,3,0; the rready period is 87 cycles (84+2+1).
- i_rx_enable dropped at burst word 40: rready stays high to word 83, then GAP, then IDLE. o_busy falls 2 cycles after burst end.
- i_lane_en=4'b1010, all valid: only lanes 1 and 3 are granted, alternating.
- rd_rst asserted at burst word 10: o_rready=0 and o_sel_vld=0 with no clock edge. After release, the first grant goes to lane 0.
- With CPRI_RX_SCHED_STAT_EN: 5 bursts on lane 1 give o_chip_cnt[1]=5. 100 enabled cycles with no requests give o_stall_cnt=100.

Source files
------------

// File: rtl/cpri_rx_pkg.sv
// cpri_rx_pkg
// Shared definitions for the CPRI receive-side scheduler:
//   sched_st_t       - scheduler FSM states
//   CPRI_CHIP_WORDS  - words per chip (read addresses 7..90 inclusive)
//   CPRI_FIRST_ADDR  - first lane buffer word address of a chip
//   CPRI_LAST_ADDR   - last lane buffer word address of a chip
//   sel_width()      - select width that stays at least one bit for a single lane
package cpri_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    BURST = 2'd2,
    GAP   = 2'd3
  } sched_st_t;

  localparam int CPRI_FIRST_ADDR = 7;
  localparam int CPRI_LAST_ADDR  = 90;
  localparam int CPRI_CHIP_WORDS = CPRI_LAST_ADDR - CPRI_FIRST_ADDR + 1;

  // A single-lane build still needs a one-bit select so the ports stay legal.
  function automatic int sel_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/cpri_rx_sched_rr_arbiter.sv
// rr_arbiter
// Combinational circular priority pick: returns the first requesting lane at
// or after the round-robin pointer, wrapping past the highest lane.
// Ports:
//   i_req        LANE_NUM  request vector
//   i_rr_ptr     SEL_W     lane with highest priority this round
//   o_grant      SEL_W     chosen lane index (0 when nothing requests)
//   o_grant_vld  1         at least one request present
module rr_arbiter #(
  parameter int LANE_NUM = 4,
  parameter int SEL_W    = 2
) (
  input  logic [LANE_NUM-1:0] i_req,
  input  logic [SEL_W-1:0]    i_rr_ptr,
  output logic [SEL_W-1:0]    o_grant,
  output logic                o_grant_vld
);

  // Walk the offsets from the farthest to the nearest so the lane closest to
  // the pointer is the last one written and therefore wins.
  always_comb begin
    int w_idx;
    logic [SEL_W-1:0] w_lane;
    o_grant     = '0;
    o_grant_vld = 1'b0;
    w_idx       = 0;
    w_lane      = '0;
    for (int i = LANE_NUM - 1; i >= 0; i--) begin
      w_idx = int'(i_rr_ptr) + i;
      if (w_idx >= LANE_NUM) begin
        w_idx = w_idx - LANE_NUM;
      end
      w_lane = w_idx[SEL_W-1:0];
      if (i_req[w_lane]) begin
        o_grant     = w_lane;
        o_grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpri_rx_sched.sv
// cpri_rx_sched
// Round-robin read scheduler for LANE_NUM CPRI RX loop-buffer readers. One
// lane at a time gets an uninterruptible burst of CHIP_WORDS rready cycles,
// followed by GAP_CYCLES idle cycles and one arbitration cycle. A pipeline of
// SEL_LATENCY stages realigns lane select and chip framing with the IQ data
// that appears at the lane outputs.
// Optional feature macro: CPRI_RX_SCHED_STAT_EN adds per-lane chip counters
// (o_chip_cnt) and a saturating starvation counter (o_stall_cnt).
// Ports:
//   rd_clk       1         scheduler clock (lane read domain)
//   rd_rst       1         asynchronous active-high reset
//   i_rx_enable  1         global scheduling enable
//   i_lane_en    LANE_NUM  static per-lane enable mask
//   i_lane_vld   LANE_NUM  lane holds at least one complete chip
//   o_rready     LANE_NUM  one-hot read-ready to the lanes
//   o_sel        SEL_W     lane index aligned to output data
//   o_sel_vld    1         o_sel/data valid
//   o_sof        1         first word of a chip at the output
//   o_eof        1         last word of a chip at the output
//   o_chip_done  1         pulse on the last rready cycle of a burst (unaligned)
//   o_busy       1         scheduler not idle
//   o_chip_cnt   LANE_NUMx16 per-lane wrapping chip counters (stat build only)
//   o_stall_cnt  16        saturating count of starved ARB cycles (stat build only)
module cpri_rx_sched
  import cpri_rx_pkg::*;
#(
  parameter int LANE_NUM    = 4,
  parameter int CHIP_WORDS  = CPRI_CHIP_WORDS,
  parameter int GAP_CYCLES  = 2,
  parameter int SEL_LATENCY = 3,
  parameter int SEL_W       = sel_width(LANE_NUM)
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                i_rx_enable,
  input  logic [LANE_NUM-1:0] i_lane_en,
  input  logic [LANE_NUM-1:0] i_lane_vld,
  output logic [LANE_NUM-1:0] o_rready,
  output logic [SEL_W-1:0]    o_sel,
  output logic                o_sel_vld,
  output logic                o_sof,
  output logic                o_eof,
  output logic                o_chip_done,
  output logic                o_busy
`ifdef CPRI_RX_SCHED_STAT_EN
  ,
  output logic [LANE_NUM-1:0][15:0] o_chip_cnt,
  output logic [15:0]               o_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(CHIP_WORDS);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CHIP_WORDS - 1);
  localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANE_NUM - 1);

  sched_st_t        r_state, w_nxt_state;
  logic [SEL_W-1:0] r_grant, w_nxt_grant;
  logic [SEL_W-1:0] r_rr_ptr, w_nxt_rr_ptr;
  logic [CNT_W-1:0] r_word_cnt, w_nxt_word_cnt;
  logic [GAP_W-1:0] r_gap_cnt, w_nxt_gap_cnt;
  logic             w_chip_done;
  logic             w_burst;

  logic [LANE_NUM-1:0] w_req;
  logic [SEL_W-1:0]    w_arb_grant;
  logic                w_arb_vld;

  logic [SEL_LATENCY-1:0]            r_vld_pipe;
  logic [SEL_LATENCY-1:0]            r_sof_pipe;
  logic [SEL_LATENCY-1:0]            r_eof_pipe;
  logic [SEL_LATENCY-1:0][SEL_W-1:0] r_sel_pipe;

  assign w_req   = i_lane_vld & i_lane_en;
  assign w_burst = (r_state == BURST);

  rr_arbiter #(
    .LANE_NUM (LANE_NUM),
    .SEL_W    (SEL_W)
  ) u_rr_arbiter (
    .i_req       (w_req),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_arb_grant),
    .o_grant_vld (w_arb_vld)
  );

  // State and burst bookkeeping registers.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_word_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_grant    <= w_nxt_grant;
      r_rr_ptr   <= w_nxt_rr_ptr;
      r_word_cnt <= w_nxt_word_cnt;
      r_gap_cnt  <= w_nxt_gap_cnt;
    end
  end

  // BURST ignores enable and request changes entirely: cutting a burst short
  // would leave the lane's read address off its chip boundary.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_grant    = r_grant;
    w_nxt_rr_ptr   = r_rr_ptr;
    w_nxt_word_cnt = r_word_cnt;
    w_nxt_gap_cnt  = r_gap_cnt;
    w_chip_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_rx_enable) begin
          w_nxt_state = ARB;
        end
      end
      ARB: begin
        if (!i_rx_enable) begin
          w_nxt_state = IDLE;
        end else if (w_arb_vld) begin
          w_nxt_grant    = w_arb_grant;
          w_nxt_rr_ptr   = (w_arb_grant == LAST_LANE) ? '0 : w_arb_grant + 1'b1;
          w_nxt_word_cnt = '0;
          w_nxt_state    = BURST;
        end
      end
      BURST: begin
        if (r_word_cnt == LAST_WORD) begin
          w_chip_done    = 1'b1;
          w_nxt_word_cnt = '0;
          w_nxt_gap_cnt  = '0;
          w_nxt_state    = GAP;
        end else begin
          w_nxt_word_cnt = r_word_cnt + 1'b1;
        end
      end
      GAP: begin
        if (r_gap_cnt == LAST_GAP) begin
          w_nxt_gap_cnt = '0;
          w_nxt_state   = i_rx_enable ? ARB : IDLE;
        end else begin
          w_nxt_gap_cnt = r_gap_cnt + 1'b1;
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  always_comb begin
    o_rready = '0;
    if (w_burst) begin
      o_rready[r_grant] = 1'b1;
    end
  end

  // Alignment pipeline: the lane presents IQ data SEL_LATENCY cycles after
  // rready, so select and framing travel through the same number of stages.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_vld_pipe <= '0;
      r_sof_pipe <= '0;
      r_eof_pipe <= '0;
      r_sel_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= w_burst;
      r_sel_pipe[0] <= w_burst ? r_grant : '0;
      r_sof_pipe[0] <= w_burst && (r_word_cnt == '0);
      r_eof_pipe[0] <= w_burst && (r_word_cnt == LAST_WORD);
      for (int i = 1; i < SEL_LATENCY; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        r_sel_pipe[i] <= r_sel_pipe[i-1];
        r_sof_pipe[i] <= r_sof_pipe[i-1];
        r_eof_pipe[i] <= r_eof_pipe[i-1];
      end
    end
  end

  assign o_sel_vld   = r_vld_pipe[SEL_LATENCY-1];
  assign o_sel       = r_sel_pipe[SEL_LATENCY-1];
  assign o_sof       = r_vld_pipe[SEL_LATENCY-1] & r_sof_pipe[SEL_LATENCY-1];
  assign o_eof       = r_vld_pipe[SEL_LATENCY-1] & r_eof_pipe[SEL_LATENCY-1];
  assign o_chip_done = w_chip_done;
  assign o_busy      = (r_state != IDLE);

`ifdef CPRI_RX_SCHED_STAT_EN
  logic [LANE_NUM-1:0][15:0] r_chip_cnt;
  logic [15:0]               r_stall_cnt;

  // Chip counters wrap; the stall counter sticks at all-ones so a long
  // starvation period is still visible.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_chip_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_chip_done) begin
        r_chip_cnt[r_grant] <= r_chip_cnt[r_grant] + 16'd1;
      end
      if ((r_state == ARB) && i_rx_enable && (w_req == '0) && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign o_chip_cnt  = r_chip_cnt;
  assign o_stall_cnt = r_stall_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
